// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10,
    MARK = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int unsigned BITS_W        = 4;
  localparam int unsigned MIN_DATA_BITS = 5;

  // Clamp a requested data length into MIN_DATA_BITS..max_bits.
  function automatic logic [BITS_W-1:0] clamp_bits(input logic [BITS_W-1:0] req,
                                                   input int unsigned max_bits);
    logic [BITS_W-1:0] res;
    res = req;
    if (32'(req) < MIN_DATA_BITS) begin
      res = BITS_W'(MIN_DATA_BITS);
    end else if (32'(req) > max_bits) begin
      res = BITS_W'(max_bits);
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Processor-side write port and FIFO status of the UART transmitter.
interface uart_tx_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LVL_W  = 5
) ();

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full;
  logic              fifo_empty;
  logic              irq;

  modport master (
    output wr_en, wr_data,
    input  fifo_level, fifo_full, fifo_empty, irq
  );

  modport slave (
    input  wr_en, wr_data,
    output fifo_level, fifo_full, fifo_empty, irq
  );

endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO with fill level; writes while full are dropped.
module uart_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  logic [DATA_W-1:0]               wr_data,
  output logic [DATA_W-1:0]               rd_data,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            full,
  output logic                            empty
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  // Qualify requests and advance pointers/level.
  always_comb begin
    do_push  = push && (level_q != LVL_W'(FIFO_DEPTH));
    do_pop   = pop && (level_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign full    = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty   = (level_q == '0);

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: FIFO, CTS synchroniser, frame FSM, baud counter and shifter.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_param_if.slave    bus,
  input  logic [DIV_W-1:0]  cfg_baud_div,
  input  logic [3:0]        cfg_data_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_two_stop,
  input  logic [LVL_W-1:0]  cfg_irq_level,
  input  logic              cts_n,
  input  logic              break_req,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BITS_W-1:0] bits_q, bits_d;
  logic [BITS_W-1:0] idx_q, idx_d;
  parity_e           parity_q, parity_d;
  logic              two_stop_q, two_stop_d;
  logic              par_bit_q, par_bit_d;
  logic              tx_out_q, tx_out_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tx_done_q, tx_done_d;
  logic              cts_meta_q, cts_s_q;

  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full, fifo_empty;
  logic              bit_end, can_start, load;

  uart_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (bus.wr_en),
    .pop     (fifo_pop),
    .wr_data (bus.wr_data),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.fifo_level = fifo_level;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_empty = fifo_empty;
  assign bus.irq        = (fifo_level <= cfg_irq_level);

  // Parity over the low n bits of a frame's data.
  function automatic logic calc_parity(input logic [DATA_W-1:0] d,
                                       input logic [BITS_W-1:0] n,
                                       input parity_e           p);
    logic x;
    x = 1'b0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i < int'(n)) x = x ^ d[i];
    end
    case (p)
      EVEN:    return x;
      ODD:     return ~x;
      MARK:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Two-flop synchroniser for cts_n; resets to "not clear".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_meta_q <= 1'b1;
      cts_s_q    <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_s_q    <= cts_meta_q;
    end
  end

  // Next-state, bit timing and next line value.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    shift_d    = shift_q;
    bits_d     = bits_q;
    idx_d      = idx_q;
    parity_d   = parity_q;
    two_stop_d = two_stop_q;
    par_bit_d  = par_bit_q;
    tx_out_d   = tx_out_q;
    tx_done_d  = 1'b0;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    bit_end    = (cnt_q == div_q);
    can_start  = !fifo_empty && !cts_s_q;

    if (state_q != IDLE && state_q != BREAK) begin
      cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);
    end else begin
      cnt_d = '0;
    end

    case (state_q)
      IDLE: begin
        tx_out_d = STOP_BIT;
        if (break_req) begin
          state_d  = BREAK;
          tx_out_d = 1'b0;
        end else if (can_start) begin
          load = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          idx_d    = '0;
          tx_out_d = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == bits_q - BITS_W'(1)) begin
            if (parity_q != NONE) begin
              state_d  = PARITY;
              tx_out_d = par_bit_q;
            end else begin
              state_d  = STOP;
              idx_d    = '0;
              tx_out_d = STOP_BIT;
            end
          end else begin
            idx_d    = idx_q + BITS_W'(1);
            shift_d  = shift_q >> 1;
            tx_out_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          idx_d    = '0;
          tx_out_d = STOP_BIT;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (two_stop_q && idx_q == '0) begin
            idx_d = BITS_W'(1);
          end else begin
            tx_done_d = 1'b1;
            if (break_req) begin
              state_d  = BREAK;
              tx_out_d = 1'b0;
            end else if (can_start) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      BREAK: begin
        tx_out_d = 1'b0;
        if (!break_req) begin
          state_d  = IDLE;
          tx_out_d = STOP_BIT;
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = STOP_BIT;
      end
    endcase

    // Frame start: pop the head word and freeze the frame configuration.
    if (load) begin
      state_d    = START;
      fifo_pop   = 1'b1;
      shift_d    = fifo_rd_data;
      bits_d     = clamp_bits(cfg_data_bits, DATA_W);
      parity_d   = parity_e'(cfg_parity);
      two_stop_d = cfg_two_stop;
      div_d      = cfg_baud_div;
      cnt_d      = '0;
      idx_d      = '0;
      par_bit_d  = calc_parity(fifo_rd_data, bits_d, parity_d);
      tx_out_d   = START_BIT;
    end

    tx_busy_d = (state_d != IDLE);
  end

  // FSM and frame registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      bits_q     <= '0;
      idx_q      <= '0;
      parity_q   <= NONE;
      two_stop_q <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_out_q   <= STOP_BIT;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      bits_q     <= bits_d;
      idx_q      <= idx_d;
      parity_q   <= parity_d;
      two_stop_q <= two_stop_d;
      par_bit_q  <= par_bit_d;
      tx_out_q   <= tx_out_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx_out  = tx_out_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: framing, parity, FIFO/CTS, break, reset, config latching.
module tb_uart_tx_param;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned LVL_W      = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [DIV_W-1:0]  cfg_baud_div;
  logic [3:0]        cfg_data_bits;
  logic [1:0]        cfg_parity;
  logic              cfg_two_stop;
  logic [LVL_W-1:0]  cfg_irq_level;
  logic              cts_n;
  logic              break_req;
  logic              tx_out;
  logic              tx_busy;
  logic              tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx_param_if #(.DATA_W(DATA_W), .LVL_W(LVL_W)) bus_if ();

  uart_tx_param #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W),
    .LVL_W      (LVL_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus_if),
    .cfg_baud_div  (cfg_baud_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_two_stop  (cfg_two_stop),
    .cfg_irq_level (cfg_irq_level),
    .cts_n         (cts_n),
    .break_req     (break_req),
    .tx_out        (tx_out),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_data = d;
    tick();
    bus_if.wr_en   = 1'b0;
  endtask

  // Record the line for n cycles plus where tx_done pulsed.
  task automatic capture(input int n, output logic [255:0] w, output int first_done,
                         output int done_cnt);
    w = '0;
    first_done = -1;
    done_cnt = 0;
    for (int k = 0; k < n; k++) begin
      w[k] = tx_out;
      if (tx_done === 1'b1) begin
        if (first_done < 0) first_done = k;
        done_cnt++;
      end
      tick();
    end
  endtask

  // Expected per-cycle line: bit i of b (time order) held for per cycles.
  function automatic logic [255:0] expand(input logic [31:0] b, input int n, input int per);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < per; j++) w[i*per+j] = b[i];
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx_out: got %b want 1", tx_out); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_done); end
    checks++; if (bus_if.fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus_if.fifo_level); end
    checks++; if (bus_if.fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus_if.fifo_empty); end
    checks++; if (bus_if.fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus_if.fifo_full); end
    checks++; if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL reset_irq: got %b want 1", bus_if.irq); end
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_8n1();
    logic [255:0] w;
    int fd, dc;
    cfg_baud_div = 16'd3; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
    write_word(8'hA5);
    checks++; if (bus_if.fifo_level !== 5'd1) begin errors++; $display("FAIL 8n1_level_after_write: got %0d want 1", bus_if.fifo_level); end
    tick();
    checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL 8n1_start_latency: got %b want 0", tx_out); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL 8n1_busy: got %b want 1", tx_busy); end
    capture(40, w, fd, dc);
    checks++; if (w !== expand({1'b1, 8'hA5, 1'b0}, 10, 4)) begin errors++; $display("FAIL 8n1_wave: got %h want %h", w, expand({1'b1, 8'hA5, 1'b0}, 10, 4)); end
    checks++; if (dc !== 0) begin errors++; $display("FAIL 8n1_early_done: got %0d pulses want 0", dc); end
    checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL 8n1_done_at_40: got %b want 1", tx_done); end
    tick();
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL 8n1_done_width: got %b want 0", tx_done); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL 8n1_idle_busy: got %b want 0", tx_busy); end
  endtask

  task automatic test_parity();
    logic [255:0] w, e, f;
    int fd, dc;
    logic [1:0] pm [3];
    logic       pb [3];
    pm = '{2'b01, 2'b10, 2'b11};
    pb = '{1'b0, 1'b1, 1'b1};
    cfg_baud_div = 16'd1; cfg_data_bits = 4'd7; cfg_two_stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_parity = pm[i];
      write_word(8'hD5);
      tick();
      capture(20, w, fd, dc);
      e = expand({1'b1, pb[i], 7'h55, 1'b0}, 10, 2);
      checks++; if (w !== e) begin errors++; $display("FAIL parity_wave mode=%0d: got %h want %h", pm[i], w, e); end
      checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL parity_done mode=%0d: got %b want 1", pm[i], tx_done); end
      tick();
    end
    // Two stop bits, two queued frames: 8 high cycles then the next start.
    cfg_baud_div = 16'd3; cfg_parity = 2'b01; cfg_two_stop = 1'b1;
    write_word(8'hD5);
    write_word(8'hD5);
    capture(88, w, fd, dc);
    f = expand({2'b11, 1'b0, 7'h55, 1'b0}, 11, 4);
    e = f | (f << 44);
    checks++; if (w !== e) begin errors++; $display("FAIL two_stop_wave: got %h want %h", w, e); end
    checks++; if (fd !== 44) begin errors++; $display("FAIL two_stop_done_cycle: got %0d want 44", fd); end
    checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL two_stop_second_done: got %b want 1", tx_done); end
    tick();
    cfg_parity = 2'b00; cfg_two_stop = 1'b0; cfg_data_bits = 4'd8;
  endtask

  task automatic test_fifo_cts();
    logic [255:0] w, e;
    logic [7:0]   d;
    int fd, dc, waited;
    logic line_low;
    cfg_baud_div = 16'd0; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_irq_level = 5'd0;
    cts_n = 1'b1;
    repeat (3) tick();
    line_low = 1'b0;
    for (int i = 0; i < 17; i++) begin
      write_word(8'(i * 17 + 3));
      if (tx_out !== 1'b1) line_low = 1'b1;
    end
    repeat (4) begin tick(); if (tx_out !== 1'b1) line_low = 1'b1; end
    checks++; if (bus_if.fifo_level !== 5'd16) begin errors++; $display("FAIL fifo_level_full: got %0d want 16", bus_if.fifo_level); end
    checks++; if (bus_if.fifo_full !== 1'b1) begin errors++; $display("FAIL fifo_full_flag: got %b want 1", bus_if.fifo_full); end
    checks++; if (bus_if.fifo_empty !== 1'b0) begin errors++; $display("FAIL fifo_empty_when_full: got %b want 0", bus_if.fifo_empty); end
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL irq_above_thresh: got %b want 0", bus_if.irq); end
    checks++; if (line_low !== 1'b0) begin errors++; $display("FAIL cts_blocked_line: got low=%b want 0", line_low); end
    cfg_irq_level = 5'd16;
    #1;
    checks++; if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL irq_at_thresh: got %b want 1", bus_if.irq); end
    cfg_irq_level = 5'd0;
    cts_n = 1'b0;
    waited = 0;
    while (tx_out !== 1'b0 && waited < 4) begin tick(); waited++; end
    checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL cts_start_timeout: got %b want 0 within 4 cycles", tx_out); end
    capture(160, w, fd, dc);
    e = '0;
    for (int fr = 0; fr < 16; fr++) begin
      d = 8'(fr * 17 + 3);
      e[fr*10] = 1'b0;
      for (int b = 0; b < 8; b++) e[fr*10+1+b] = d[b];
      e[fr*10+9] = 1'b1;
    end
    checks++; if (w !== e) begin errors++; $display("FAIL b2b_wave: got %h want %h", w, e); end
    checks++; if (dc !== 15) begin errors++; $display("FAIL b2b_done_count: got %0d want 15", dc); end
    checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL b2b_last_done: got %b want 1", tx_done); end
    checks++; if (bus_if.fifo_empty !== 1'b1) begin errors++; $display("FAIL drained_empty: got %b want 1", bus_if.fifo_empty); end
    checks++; if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL drained_irq: got %b want 1", bus_if.irq); end
    capture(12, w, fd, dc);
    checks++; if (w !== 256'(12'hFFF)) begin errors++; $display("FAIL dropped_word_sent: got %h want fff", w); end
  endtask

  task automatic test_break();
    logic [255:0] w, e;
    int fd, dc;
    logic bad;
    cfg_baud_div = 16'd1; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
    write_word(8'h3C);
    tick();
    w = '0; dc = 0;
    for (int k = 0; k < 20; k++) begin
      w[k] = tx_out;
      if (tx_done === 1'b1) dc++;
      bus_if.wr_en   = (k == 0);
      bus_if.wr_data = 8'h81;
      if (k == 5) break_req = 1'b1;
      tick();
    end
    bus_if.wr_en = 1'b0;
    e = expand({1'b1, 8'h3C, 1'b0}, 10, 2);
    checks++; if (w !== e) begin errors++; $display("FAIL break_frame_wave: got %h want %h", w, e); end
    checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL break_frame_done: got %b want 1", tx_done); end
    checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL break_line_low: got %b want 0", tx_out); end
    bad = 1'b0;
    repeat (10) begin tick(); if (tx_out !== 1'b0 || tx_busy !== 1'b1) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL break_hold: got glitch=%b want 0", bad); end
    checks++; if (bus_if.fifo_level !== 5'd1) begin errors++; $display("FAIL break_level: got %0d want 1", bus_if.fifo_level); end
    break_req = 1'b0;
    tick();
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL break_release_line: got %b want 1", tx_out); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL break_release_busy: got %b want 0", tx_busy); end
    tick();
    capture(20, w, fd, dc);
    e = expand({1'b1, 8'h81, 1'b0}, 10, 2);
    checks++; if (w !== e) begin errors++; $display("FAIL after_break_wave: got %h want %h", w, e); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [255:0] w, e;
    int fd, dc;
    logic done_seen, line_bad;
    cfg_baud_div = 16'd3; cfg_data_bits = 4'd8; cfg_parity = 2'b00;
    write_word(8'h00);
    write_word(8'h0F);
    repeat (10) tick();
    checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL mid_data_line: got %b want 0", tx_out); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL async_reset_line: got %b want 1", tx_out); end
    checks++; if (bus_if.fifo_level !== 5'd0) begin errors++; $display("FAIL async_reset_level: got %0d want 0", bus_if.fifo_level); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", tx_busy); end
    done_seen = 1'b0; line_bad = 1'b0;
    repeat (3) begin tick(); if (tx_done !== 1'b0) done_seen = 1'b1; if (tx_out !== 1'b1) line_bad = 1'b1; end
    reset = 1'b0;
    repeat (3) begin tick(); if (tx_done !== 1'b0) done_seen = 1'b1; if (tx_out !== 1'b1) line_bad = 1'b1; end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL reset_no_done: got pulse=%b want 0", done_seen); end
    checks++; if (line_bad !== 1'b0 || tx_busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got line_bad=%b busy=%b want 0 0", line_bad, tx_busy); end
    write_word(8'hC3);
    tick();
    capture(40, w, fd, dc);
    e = expand({1'b1, 8'hC3, 1'b0}, 10, 4);
    checks++; if (w !== e) begin errors++; $display("FAIL post_reset_wave: got %h want %h", w, e); end
    tick();
  endtask

  task automatic test_cfg_change();
    logic [255:0] w, e;
    int fd, dc;
    cfg_baud_div = 16'd1; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
    write_word(8'hB2);
    write_word(8'h4D);
    fork
      capture(41, w, fd, dc);
      begin
        repeat (6) tick();
        cfg_baud_div  = 16'd2;
        cfg_data_bits = 4'd2;
      end
    join
    e = expand({1'b1, 8'hB2, 1'b0}, 10, 2) | (expand({1'b1, 5'b01101, 1'b0}, 7, 3) << 20);
    checks++; if (w !== e) begin errors++; $display("FAIL cfg_change_wave: got %h want %h", w, e); end
    checks++; if (fd !== 20) begin errors++; $display("FAIL cfg_change_first_done: got %0d want 20", fd); end
    checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL cfg_change_second_done: got %b want 1", tx_done); end
    tick();
    cfg_baud_div = 16'd3; cfg_data_bits = 4'd8;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus_if.wr_en   = 1'b0;
    bus_if.wr_data = '0;
    cfg_baud_div   = 16'd3;
    cfg_data_bits  = 4'd8;
    cfg_parity     = 2'b00;
    cfg_two_stop   = 1'b0;
    cfg_irq_level  = 5'd0;
    cts_n          = 1'b0;
    break_req      = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_fifo_cts();
    test_break();
    test_reset_mid();
    test_cfg_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
